// File: rtl/cpu_clock_sequencer.sv
// cpu_clock_sequencer: command-driven clock-enable sequencer for the MIPS core.
// Produces single-cycle cpu_en pulses at a programmable divide ratio in RUN,
// STEP (one pulse) or BURST (N pulses) mode. halt_req forces an immediate
// return to IDLE and suppresses any further pulse.
module cpu_clock_sequencer #(
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 16,
  parameter int RESET_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [31:0]      pulse_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STEP  = 2'd2;
  localparam logic [1:0] BURST = 2'd3;

  localparam logic [1:0] OP_HALT  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;

  logic [1:0]       state;
  logic [DIV_W-1:0] divR;
  logic [DIV_W-1:0] divCnt;
  logic [DIV_W-1:0] divEff;
  logic [CNT_W-1:0] stepsLeft;
  logic             accept;
  logic             phaseEnd;
  logic             finishing;

  // A divide ratio of 0 behaves like 1 so the core is never starved.
  assign divEff    = (divR == '0) ? DIV_W'(1) : divR;
  assign phaseEnd  = (divCnt == divEff - DIV_W'(1));
  assign cmd_ready = ((state == IDLE) || (state == RUN)) && !halt_req;
  assign accept    = cmd_valid && cmd_ready;
  // STEP ends the edge after its pulse; BURST ends once all steps are spent.
  assign finishing = ((state == STEP) && cpu_en) ||
                     ((state == BURST) && (stepsLeft == '0));

  // Sequencer state, phase counter and registered outputs; halt beats commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      divR      <= DIV_W'(RESET_DIV);
      divCnt    <= '0;
      stepsLeft <= '0;
      cpu_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      cpu_en  <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      if (halt_req) begin
        aborted <= (state == STEP) || (state == BURST);
        state   <= IDLE;
        busy    <= 1'b0;
        divCnt  <= '0;
      end else if (accept) begin
        divCnt <= '0;
        case (cmd_op)
          OP_HALT: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          OP_RUN: begin
            state <= RUN;
            busy  <= 1'b0;
            divR  <= cmd_div;
          end
          OP_STEP: begin
            state <= STEP;
            busy  <= 1'b1;
            divR  <= cmd_div;
          end
          default: begin
            divR      <= cmd_div;
            stepsLeft <= cmd_count;
            if (cmd_count == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= BURST;
              busy  <= 1'b1;
            end
          end
        endcase
      end else if (finishing) begin
        state  <= IDLE;
        busy   <= 1'b0;
        done   <= 1'b1;
        divCnt <= '0;
      end else if (state != IDLE) begin
        if (phaseEnd) begin
          divCnt    <= '0;
          cpu_en    <= 1'b1;
          pulse_cnt <= pulse_cnt + 32'd1;
          if (state == BURST) begin
            stepsLeft <= stepsLeft - CNT_W'(1);
          end
        end else begin
          divCnt <= divCnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Testbench for cpu_clock_sequencer: directed scenarios plus random commands,
// checked every cycle against a behavioural model of the sequencer.
module tb_cpu_clock_sequencer;

  localparam logic [1:0] OP_HALT  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_BURST = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_div = 8'd0;
  logic [15:0] cmd_count = 16'd0;
  logic        halt_req = 1'b0;
  logic        cpu_en;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] pulse_cnt;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  cpu_clock_sequencer #(.DIV_W(8), .CNT_W(16), .RESET_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_div(cmd_div), .cmd_count(cmd_count),
    .halt_req(halt_req), .cpu_en(cpu_en), .busy(busy), .done(done),
    .aborted(aborted), .pulse_cnt(pulse_cnt)
  );

  task automatic checkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 run, 2 step, 3 burst. A pulse is due
  // whenever the edges elapsed since the accepting edge are a multiple of d.
  int          mMode = 0;
  int          mT = 0;
  int          mStart = 0;
  int          mLeft = 0;
  int          mDiv = 4;
  int          mD = 1;
  logic        eEn = 1'b0;
  logic        eDone = 1'b0;
  logic        eAbort = 1'b0;
  logic        eBusy = 1'b0;
  logic [31:0] eCnt = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mMode = 0; mT = 0; mStart = 0; mLeft = 0; mDiv = 4;
      eEn = 1'b0; eDone = 1'b0; eAbort = 1'b0; eBusy = 1'b0; eCnt = 32'd0;
    end else begin
      mT++;
      eEn = 1'b0; eDone = 1'b0; eAbort = 1'b0;
      if (halt_req) begin
        eAbort = (mMode >= 2);
        mMode  = 0;
      end else if (cmd_valid && mMode <= 1) begin
        if (cmd_op != OP_HALT) begin
          mDiv   = int'(cmd_div);
          mStart = mT;
        end
        case (cmd_op)
          OP_HALT: mMode = 0;
          OP_RUN:  mMode = 1;
          OP_STEP: begin mMode = 2; mLeft = 1; end
          default: begin
            if (cmd_count == 16'd0) begin mMode = 0; eDone = 1'b1; end
            else begin mMode = 3; mLeft = int'(cmd_count); end
          end
        endcase
      end else if (mMode != 0) begin
        mD = (mDiv == 0) ? 1 : mDiv;
        if (mMode >= 2 && mLeft == 0) begin
          mMode = 0;
          eDone = 1'b1;
        end else if ((mT - mStart) % mD == 0) begin
          eEn  = 1'b1;
          eCnt = eCnt + 32'd1;
          if (mMode >= 2) mLeft--;
        end
      end
      eBusy = (mMode >= 2);
    end
  end

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    checkBit("cpu_en", cpu_en, eEn);
    checkBit("done", done, eDone);
    checkBit("aborted", aborted, eAbort);
    checkBit("busy", busy, eBusy);
    checkWord("pulse_cnt", pulse_cnt, eCnt);
    checkBit("cmd_ready", cmd_ready, (mMode <= 1) && !halt_req);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendCmd(input logic [1:0] op, input logic [7:0] dv, input logic [15:0] cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_div = dv; cmd_count = cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int pulses, firstK, lastK, doneK, dones, aborts, k;
    logic [31:0] base;

    repeat (3) @(posedge clk);
    #1;
    checkWord("reset pulse_cnt", pulse_cnt, 32'd0);
    checkBit("reset busy", busy, 1'b0);
    checkBit("reset cpu_en", cpu_en, 1'b0);
    rst_n = 1'b1;
    tick();

    // RUN div 4: first pulse 4 edges after accept, then every 4.
    sendCmd(OP_RUN, 8'd4, 16'd0);
    pulses = 0; firstK = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (cpu_en) begin pulses++; if (firstK < 0) firstK = i; end
    end
    checkWord("run4 first pulse edge", 32'(firstK), 32'd4);
    checkWord("run4 pulses", 32'(pulses), 32'd10);
    checkWord("run4 pulse_cnt", pulse_cnt, 32'd10);
    sendCmd(OP_HALT, 8'd0, 16'd0);
    tick();

    // STEP div 3.
    base = pulse_cnt;
    sendCmd(OP_STEP, 8'd3, 16'd0);
    checkBit("step busy", busy, 1'b1);
    checkBit("step cmd_ready", cmd_ready, 1'b0);
    pulses = 0; firstK = -1; doneK = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cpu_en) begin pulses++; if (firstK < 0) firstK = i; end
      if (done && doneK < 0) doneK = i;
    end
    checkWord("step pulse edge", 32'(firstK), 32'd3);
    checkWord("step pulses", 32'(pulses), 32'd1);
    checkWord("step done edge", 32'(doneK), 32'd4);
    checkBit("step busy after", busy, 1'b0);
    checkWord("step pulse_cnt", pulse_cnt, base + 32'd1);

    // BURST 5 at div 0: five back-to-back pulses then done.
    base = pulse_cnt;
    sendCmd(OP_BURST, 8'd0, 16'd5);
    pulses = 0; firstK = -1; lastK = -1; doneK = -1; dones = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cpu_en) begin pulses++; lastK = i; if (firstK < 0) firstK = i; end
      if (done) begin dones++; if (doneK < 0) doneK = i; end
    end
    checkWord("burst5 first", 32'(firstK), 32'd1);
    checkWord("burst5 last", 32'(lastK), 32'd5);
    checkWord("burst5 pulses", 32'(pulses), 32'd5);
    checkWord("burst5 done edge", 32'(doneK), 32'd6);
    checkWord("burst5 done count", 32'(dones), 32'd1);
    checkWord("burst5 pulse_cnt", pulse_cnt, base + 32'd5);

    // BURST 0: immediate done, no pulses.
    base = pulse_cnt;
    sendCmd(OP_BURST, 8'd3, 16'd0);
    checkBit("burst0 done", done, 1'b1);
    checkBit("burst0 busy", busy, 1'b0);
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (cpu_en) pulses++;
    end
    checkWord("burst0 pulses", 32'(pulses), 32'd0);
    checkWord("burst0 pulse_cnt", pulse_cnt, base);

    // BURST 100, halted after 7 pulses.
    base = pulse_cnt;
    sendCmd(OP_BURST, 8'd2, 16'd100);
    pulses = 0; k = 0;
    while (pulses < 7 && k < 100) begin
      tick(); k++;
      if (cpu_en) pulses++;
    end
    checkWord("burst100 reached 7 pulses", 32'(pulses), 32'd7);
    halt_req = 1'b1;
    pulses = 0; aborts = 0; dones = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_en) pulses++;
      if (aborted) aborts++;
      if (done) dones++;
    end
    checkWord("halt pulses after", 32'(pulses), 32'd0);
    checkWord("halt aborted count", 32'(aborts), 32'd1);
    checkWord("halt done count", 32'(dones), 32'd0);
    checkBit("halt busy", busy, 1'b0);
    checkWord("halt pulse_cnt", pulse_cnt, base + 32'd7);

    // halt_req and cmd_valid together: halt wins.
    cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_div = 8'd1; cmd_count = 16'd0;
    #1;
    checkBit("halt vs cmd ready", cmd_ready, 1'b0);
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cpu_en) pulses++;
    end
    checkWord("halt vs cmd pulses", 32'(pulses), 32'd0);
    cmd_valid = 1'b0;
    halt_req = 1'b0;
    #1;
    checkBit("ready after halt", cmd_ready, 1'b1);
    tick();

    // RUN div 8 re-phased by RUN div 2.
    sendCmd(OP_RUN, 8'd8, 16'd0);
    repeat (3) tick();
    sendCmd(OP_RUN, 8'd2, 16'd0);
    pulses = 0; firstK = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (cpu_en) begin pulses++; if (firstK < 0) firstK = i; end
    end
    checkWord("rerun first pulse", 32'(firstK), 32'd2);
    checkWord("rerun pulses", 32'(pulses), 32'd4);
    sendCmd(OP_HALT, 8'd0, 16'd0);
    tick();

    // Asynchronous reset mid-burst.
    sendCmd(OP_BURST, 8'd1, 16'd100);
    repeat (5) tick();
    checkBit("pre-reset cpu_en", cpu_en, 1'b1);
    rst_n = 1'b0;
    #2;
    checkBit("async cpu_en", cpu_en, 1'b0);
    checkBit("async busy", busy, 1'b0);
    checkBit("async done", done, 1'b0);
    checkBit("async aborted", aborted, 1'b0);
    checkWord("async pulse_cnt", pulse_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    checkWord("div after reset", 32'(dut.divR), 32'd4);
    dones = 0; aborts = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (done) dones++;
      if (aborted) aborts++;
    end
    checkWord("post-reset done", 32'(dones), 32'd0);
    checkWord("post-reset aborted", 32'(aborts), 32'd0);

    // Random command traffic against the model.
    for (int i = 0; i < 400; i++) begin
      halt_req  = ($urandom_range(0, 19) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_div   = 8'($urandom_range(0, 5));
      cmd_count = 16'($urandom_range(0, 6));
      tick();
    end
    halt_req = 1'b0;
    cmd_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
